return_stack: RTL and testbench

Hardware return-address stack that sits directly downstream of the instruction decoder. It consumes the decoder's `push`/`pop` strobes: it saves the program counter on a subroutine call (JMS) and supplies the return address that the PC mux selects via `stack_mux` on return (BBL). It is a circular LIFO of registered entries with occupancy tracking and sticky overflow/underflow flags.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/return_stack_regfile.sv | 31 +++
 rtl/return_stack.sv | 119 +++++++++++
 tb/tb_return_stack.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default address width and the return-stack operation
// decoded from the decoder's {push, pop} strobes.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    NOP     = 2'b00,
    POP     = 2'b01,
    PUSH    = 2'b10,
    REPLACE = 2'b11
  } stack_op_t;

  function automatic stack_op_t decode_stack_op(input logic push, input logic pop);
    return stack_op_t'({push, pop});
  endfunction

endpackage

// File: rtl/return_stack_regfile.sv
// DEPTH x ADDR_W entry array for the return stack: one synchronous write port,
// one asynchronous read port, asynchronous active-low reset to zero.
module return_stack_regfile #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [ADDR_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [ADDR_W-1:0] o_rdata
);

  logic [ADDR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_stack.sv
// Circular LIFO return-address stack with occupancy tracking.
// Optional sticky ovf/udf flags with err_clr are built when RETURN_STACK_ERR_EN is defined.
module return_stack
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] ret_addr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  input  logic              err_clr,
  output logic              ovf,
  output logic              udf
);

  logic [PTR_W-1:0]  r_sp;
  logic [CNT_W-1:0]  r_count;
  stack_op_t         w_op;
  logic              w_empty;
  logic              w_full;
  logic [PTR_W-1:0]  w_top_idx;
  logic [PTR_W-1:0]  w_waddr;
  logic [ADDR_W-1:0] w_rdata;

  assign w_op      = decode_stack_op(push, pop);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_top_idx = r_sp - PTR_W'(1);

  // Replace rewrites the current top; every other push writes the free slot,
  // which on a full stack is the oldest entry.
  assign w_waddr = (w_op == REPLACE && !w_empty) ? w_top_idx : r_sp;

  return_stack_regfile #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (push),
    .i_waddr (w_waddr),
    .i_wdata (pc_in),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp    <= '0;
      r_count <= '0;
    end else begin
      unique case (w_op)
        PUSH: begin
          r_sp <= r_sp + PTR_W'(1);
          if (!w_full) r_count <= r_count + CNT_W'(1);
        end
        POP: begin
          if (!w_empty) begin
            r_sp    <= r_sp - PTR_W'(1);
            r_count <= r_count - CNT_W'(1);
          end
        end
        REPLACE: begin
          if (w_empty) begin
            r_sp    <= r_sp + PTR_W'(1);
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ret_addr = w_empty ? '0 : w_rdata;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;

`ifdef RETURN_STACK_ERR_EN
  logic r_ovf;
  logic r_udf;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_ovf_set = (w_op == PUSH) && w_full;
  assign w_udf_set = (w_op == POP) && w_empty;

  // A same-cycle set wins over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_udf_set)    r_udf <= 1'b1;
      else if (err_clr) r_udf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
  assign udf = r_udf;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: queue-based LIFO model compared every
// cycle, plus directed sequences with literal expectations.
module tb_return_stack;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
`ifdef RETURN_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [ADDR_W-1:0] pc_in = '0;
  logic              err_clr = 1'b0;
  logic [ADDR_W-1:0] ret_addr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              udf;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  bit cmp_en = 1'b0;

  return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .pc_in    (pc_in),
    .ret_addr (ret_addr),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .err_clr  (err_clr),
    .ovf      (ovf),
    .udf      (udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_top();
    return (q.size() == 0) ? 0 : int'(q[q.size()-1]);
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input bit p, input bit o, input logic [ADDR_W-1:0] pc, input bit clr);
    bit so = 1'b0;
    bit su = 1'b0;
    if (p && !o) begin
      if (q.size() == DEPTH) begin
        void'(q.pop_front());
        so = 1'b1;
      end
      q.push_back(pc);
    end else if (!p && o) begin
      if (q.size() == 0) su = 1'b1;
      else void'(q.pop_back());
    end else if (p && o) begin
      if (q.size() == 0) q.push_back(pc);
      else q[q.size()-1] = pc;
    end
    m_ovf = so ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_udf = su ? 1'b1 : (clr ? 1'b0 : m_udf);
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, settle 1 time unit.
  task automatic cycle(input bit p, input bit o, input logic [ADDR_W-1:0] pc, input bit clr);
    push = p; pop = o; pc_in = pc; err_clr = clr;
    @(posedge clk);
    if (rst_n) model_step(p, o, pc, clr);
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ret_addr", int'(ret_addr), exp_top());
      check("count", int'(count), q.size());
      check("empty", int'(empty), int'(q.size() == 0));
      check("full", int'(full), int'(q.size() == DEPTH));
      check("ovf", int'(ovf), ERR_EN ? int'(m_ovf) : 0);
      check("udf", int'(udf), ERR_EN ? int'(m_udf) : 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_before;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    // Push/pop order
    cycle(1, 0, 8'h11, 0);
    cycle(1, 0, 8'h22, 0);
    cycle(1, 0, 8'h33, 0);
    check("order_top", int'(ret_addr), 'h33);
    check("order_count", int'(count), 3);
    cycle(0, 1, 8'h00, 0);
    check("order_pop1", int'(ret_addr), 'h22);
    cycle(0, 1, 8'h00, 0);
    check("order_pop2", int'(ret_addr), 'h11);
    cycle(0, 1, 8'h00, 0);
    check("order_pop3", int'(ret_addr), 0);
    check("order_empty", int'(empty), 1);

    // Overflow and wrap-around
    for (int i = 1; i <= 5; i++) cycle(1, 0, ADDR_W'(i), 0);
    check("ovf_count", int'(count), 4);
    check("ovf_full", int'(full), 1);
    check("ovf_flag", int'(ovf), ERR_EN ? 1 : 0);
    for (int i = 5; i >= 2; i--) begin
      push = 1'b0; pop = 1'b1; #1;
      check("ovf_pop_top", int'(ret_addr), i);
      cycle(0, 1, 8'h00, 0);
    end
    check("ovf_drained", int'(empty), 1);
    cycle(0, 0, 8'h00, 1);
    check("ovf_cleared", int'(ovf), 0);

    // Underflow
    cycle(0, 1, 8'h00, 0);
    check("udf_count", int'(count), 0);
    check("udf_flag", int'(udf), ERR_EN ? 1 : 0);
    cycle(0, 1, 8'h00, 1);
    check("udf_set_beats_clr", int'(udf), ERR_EN ? 1 : 0);
    cycle(0, 0, 8'h00, 1);
    check("udf_cleared", int'(udf), 0);

    // Replace
    cycle(1, 0, 8'h40, 0);
    cycle(1, 1, 8'h41, 0);
    check("repl_count", int'(count), 1);
    check("repl_top", int'(ret_addr), 'h41);
    cycle(0, 1, 8'h00, 0);
    cycle(1, 1, 8'h77, 0);
    check("repl_empty_push", int'(ret_addr), 'h77);
    check("repl_empty_count", int'(count), 1);
    cycle(0, 1, 8'h00, 0);

    // Decoder-sequenced call/return
    cycle(1, 0, 8'h2A, 0);
    cycle(1, 0, 8'h50, 0);
    cycle(0, 1, 8'h00, 0);
    cnt_before = int'(count);
    push = 1'b0; pop = 1'b1; #1;
    check("bbl_pre_edge", int'(ret_addr), 'h2A);
    cycle(0, 1, 8'h00, 0);
    check("bbl_count", int'(count), cnt_before - 1);

    // Asynchronous reset mid-stream
    cycle(1, 0, 8'h99, 0);
    cycle(1, 0, 8'h98, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_ret", int'(ret_addr), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_udf", int'(udf), 0);
    cycle(1, 0, 8'h12, 0);
    rst_n = 1'b1;
    cycle(0, 0, 8'h00, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit p, o, c;
      p = ($urandom_range(0, 99) < 50);
      o = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 10);
      cycle(p, o, ADDR_W'($urandom), c);
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
